// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants.
//   fetch_state_t : fetch sequencer states
//   INSTR_BYTES   : PC increment per sequential fetch
//   RESET_VEC_DEFAULT : default PC loaded on reset
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ_S,
    WAIT_S,
    KILL_S
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry valid/ready register holding one fetched {instr, pc} toward decode.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : drop the held entry (wins over load)
//   load_i               : capture load_instr_i/load_pc_i
//   load_instr_i/pc_i    : incoming instruction and its PC
//   ready_i              : consumer accepts the held entry
//   valid_o/instr_o/pc_o : held entry
module fetch_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_instr_i,
  input  logic [WIDTH-1:0] load_pc_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      // Load may coincide with a drain: refill in the same cycle.
      valid_q <= 1'b1;
      instr_q <= load_instr_i;
      pc_q    <= load_pc_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding fetch at a time over a
// req/gnt/rvalid handshake, buffers one instruction toward decode, and squashes wrong-path
// fetches on redirect.
// Optional feature macro: FETCH_CTRL_ALIGN_CHECK_EN (reject misaligned redirect targets).
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   redirect_i, redirect_pc_i     : taken JAL/branch/JALR and its target
//   imem_req_o, imem_addr_o       : fetch request and address
//   imem_gnt_i, imem_rvalid_i, imem_rdata_i : memory grant / response
//   instr_valid_o, instr_o, instr_pc_o, instr_ready_i : decode-side valid/ready
//   misalign_o                    : one-cycle pulse on rejected misaligned redirect
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i,
  output logic             misalign_o
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_apply;
  logic             fetch_hold;
  logic             buf_valid;
  logic             buf_load;
  logic             granted;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  logic misaligned;
  logic halt_q, halt_d;
  logic misalign_q;

  assign misaligned     = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redirect_apply = redirect_i && !misaligned;

  // After a rejected target the PC is stale, so fetching stops until a good redirect.
  always_comb begin
    halt_d = halt_q;
    if (redirect_apply) begin
      halt_d = 1'b0;
    end else if (misaligned) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      misalign_q <= misaligned;
    end
  end

  assign fetch_hold = halt_q;
  assign misalign_o = misalign_q;
`else
  assign redirect_apply = redirect_i;
  assign fetch_hold     = 1'b0;
  assign misalign_o     = 1'b0;
`endif

  // Request only when the buffer will have room at the response edge.
  assign imem_req_o  = rst_ni && (state_q == REQ_S) && !fetch_hold &&
                       (!buf_valid || instr_ready_i);
  assign imem_addr_o = pc_q;
  assign granted     = imem_req_o && imem_gnt_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      REQ_S: begin
        if (granted) begin
          state_d = redirect_i ? KILL_S : WAIT_S;
        end
      end
      WAIT_S: begin
        if (imem_rvalid_i) begin
          state_d = REQ_S;
          pc_d    = pc_q + WIDTH'(INSTR_BYTES);
        end else if (redirect_i) begin
          state_d = KILL_S;
        end
      end
      KILL_S: begin
        if (imem_rvalid_i) begin
          state_d = REQ_S;
        end
      end
      default: state_d = REQ_S;
    endcase
    if (redirect_apply) begin
      pc_d = redirect_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REQ_S;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A response coinciding with a redirect is wrong-path and never reaches decode.
  assign buf_load = (state_q == WAIT_S) && imem_rvalid_i && !redirect_i;

  fetch_buf #(
    .WIDTH (WIDTH)
  ) u_fetch_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_i),
    .load_i       (buf_load),
    .load_instr_i (imem_rdata_i),
    .load_pc_i    (pc_q),
    .ready_i      (instr_ready_i),
    .valid_o      (buf_valid),
    .instr_o      (instr_o),
    .pc_o         (instr_pc_o)
  );

  assign instr_valid_o = buf_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a simple one-outstanding memory model.
module tb_fetch_ctrl;

  localparam logic [31:0] OFS = 32'h1000_0000;  // rdata = address + OFS

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready = 1'b1;
  logic        misalign_o;

  logic        gnt_en = 1'b1;
  logic        rv_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] acc_q[$];
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .WIDTH     (32),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready),
    .misalign_o    (misalign_o)
  );

  // Memory: grants in the request cycle, responds once rv_en allows; state survives reset
  // so a stale response can be presented after reset.
  assign imem_gnt_i    = imem_req_o & gnt_en;
  assign imem_rvalid_i = pend & rv_en;
  assign imem_rdata_i  = paddr + OFS;

  always @(posedge clk) begin
    if (imem_req_o && imem_gnt_i) begin
      pend  <= 1'b1;
      paddr <= imem_addr_o;
    end else if (imem_rvalid_i) begin
      pend <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_o && imem_gnt_i) addr_q.push_back(imem_addr_o);
      if (instr_valid_o && instr_ready) begin
        acc_q.push_back(instr_pc_o);
        check_eq("data", instr_o, instr_pc_o + OFS);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    return (addr_q.size() > i) ? addr_q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    gnt_en      = 1'b1;
    rv_en       = 1'b1;
    instr_ready = 1'b1;
    #1;
    check_eq("rst_req", {31'b0, imem_req_o}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_instr_pc", instr_pc_o, 32'h0);
    check_eq("rst_misalign", {31'b0, misalign_o}, 32'd0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    tick();
    tick();
    acc_q.delete();
    addr_q.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string tag);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, imem_req_o && imem_addr_o == a}, 32'd1);
  endtask

  task automatic wait_acc(input int cnt, input string tag);
    int n = 0;
    while (acc_q.size() < cnt && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, acc_q.size(), cnt);
  endtask

  initial begin
    // Sequential fetch with zero-latency memory.
    do_reset();
    check_eq("t1_first_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t1_first_addr", imem_addr_o, 32'h0);
    wait_acc(3, "t1_count");
    check_eq("t1_pc0", acc_at(0), 32'h0);
    check_eq("t1_pc1", acc_at(1), 32'h4);
    check_eq("t1_pc2", acc_at(2), 32'h8);
    check_eq("t1_addr0", addr_at(0), 32'h0);
    check_eq("t1_addr1", addr_at(1), 32'h4);
    check_eq("t1_addr2", addr_at(2), 32'h8);

    // Decode stall holds the buffer and blocks new requests.
    do_reset();
    instr_ready = 1'b0;
    tick();
    check_eq("t2_lat_grant", {31'b0, instr_valid_o}, 32'd0);
    tick();
    check_eq("t2_lat_valid", {31'b0, instr_valid_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_hold_valid", {31'b0, instr_valid_o}, 32'd1);
      check_eq("t2_hold_pc", instr_pc_o, 32'h0);
      check_eq("t2_hold_instr", instr_o, OFS);
      check_eq("t2_no_req", {31'b0, imem_req_o}, 32'd0);
    end
    instr_ready = 1'b1;
    #1;
    check_eq("t2_resume_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t2_resume_addr", imem_addr_o, 32'h4);
    tick();
    tick();
    check_eq("t2_next_valid", {31'b0, instr_valid_o}, 32'd1);
    check_eq("t2_next_pc", instr_pc_o, 32'h4);

    // Redirect while waiting on 0x8: late response is discarded.
    do_reset();
    wait_req_addr(32'h8, "t3_reach8");
    rv_en = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check_eq("t3_kill_noreq", {31'b0, imem_req_o}, 32'd0);
    check_eq("t3_misalign", {31'b0, misalign_o}, 32'd0);
    tick();
    check_eq("t3_kill_noreq2", {31'b0, imem_req_o}, 32'd0);
    rv_en = 1'b1;
    tick();
    check_eq("t3_drop_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("t3_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t3_addr", imem_addr_o, 32'h100);
    wait_acc(3, "t3_count");
    check_eq("t3_pc1", acc_at(1), 32'h4);
    check_eq("t3_pc2", acc_at(2), 32'h100);

    // Redirect coinciding with rvalid.
    do_reset();
    wait_req_addr(32'h4, "t4_reach4");
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check_eq("t4_drop_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("t4_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t4_addr", imem_addr_o, 32'h200);
    wait_acc(2, "t4_count");
    check_eq("t4_pc1", acc_at(1), 32'h200);

    // Redirect flushes a stalled buffer.
    do_reset();
    wait_req_addr(32'h4, "t5_reach4");
    tick();
    instr_ready = 1'b0;
    tick();
    check_eq("t5_buf_valid", {31'b0, instr_valid_o}, 32'd1);
    check_eq("t5_buf_pc", instr_pc_o, 32'h4);
    check_eq("t5_buf_noreq", {31'b0, imem_req_o}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check_eq("t5_flushed", {31'b0, instr_valid_o}, 32'd0);
    check_eq("t5_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t5_addr", imem_addr_o, 32'h300);
    instr_ready = 1'b1;
    wait_acc(2, "t5_count");
    check_eq("t5_pc1", acc_at(1), 32'h300);

    // Reset mid-fetch; stale response afterwards is ignored.
    do_reset();
    tick();
    rv_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
    check_eq("t6_rst_valid", {31'b0, instr_valid_o}, 32'd0);
    tick();
    gnt_en = 1'b0;
    rv_en  = 1'b1;
    rst_n  = 1'b1;
    #1;
    check_eq("t6_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t6_addr", imem_addr_o, 32'h0);
    tick();
    check_eq("t6_stale_ignored", {31'b0, instr_valid_o}, 32'd0);
    check_eq("t6_still_req", {31'b0, imem_req_o}, 32'd1);
    gnt_en = 1'b1;
    wait_acc(1, "t6_count");
    check_eq("t6_pc0", acc_at(0), 32'h0);

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    // Misaligned redirect is rejected and fetch halts until a good target.
    do_reset();
    gnt_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check_eq("t7_pulse", {31'b0, misalign_o}, 32'd1);
    check_eq("t7_noreq", {31'b0, imem_req_o}, 32'd0);
    check_eq("t7_pc_held", imem_addr_o, 32'h0);
    tick();
    check_eq("t7_pulse_end", {31'b0, misalign_o}, 32'd0);
    check_eq("t7_noreq2", {31'b0, imem_req_o}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    tick();
    redirect = 1'b0;
    check_eq("t7_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("t7_addr", imem_addr_o, 32'h104);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
